aes_enc_arbiter: RTL and testbench

AES_ENC_ARBITER -- requirements
Module: aes_enc_arbiter

---
 rtl/aes_enc_arbiter_pkg.sv | 18 +
 rtl/aes_rr_arbiter2.sv | 20 ++
 rtl/aes_enc_arbiter.sv | 110 +++++++++++
 tb/tb_aes_enc_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_enc_arbiter_pkg.sv
// Shared types and widths for the two-requester AES encryption arbiter.
// The key schedule is NUM_ROUNDS+1 round keys, round 0 in the MSBs.
package aes_enc_arbiter_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int BLOCK_W    = 128;
  localparam int KEYS_W     = (NUM_ROUNDS + 1) * BLOCK_W;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [KEYS_W-1:0]  keys_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/aes_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie the
// requester that was not served last wins.
module aes_rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/aes_enc_arbiter.sv
// Shares one multi-cycle AES encryption engine between two requesters:
// round-robin accept, LATENCY cycles of engine enable, then a held response.
module aes_enc_arbiter
  import aes_enc_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [BLOCK_W-1:0] req_data0,
  input  logic [BLOCK_W-1:0] req_data1,
  input  logic [KEYS_W-1:0]  req_keys0,
  input  logic [KEYS_W-1:0]  req_keys1,
  output logic [BLOCK_W-1:0] eng_data,
  output logic [KEYS_W-1:0]  eng_keys,
  output logic              eng_enable,
  input  logic [BLOCK_W-1:0] eng_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BLOCK_W-1:0] rsp_data,
  output logic              rsp_id
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             eng_en_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  block_t           eng_data_q;
  keys_t            eng_keys_q;
  block_t           rsp_data_q;

  logic [1:0]       grant;
  logic             accept;

  aes_rr_arbiter2 u_rr (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (grant)
  );

  // Ready is offered only while idle; the grant already implies valid.
  assign req_ready = (state_q == IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      eng_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      eng_data_q  <= '0;
      eng_keys_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            eng_data_q <= grant[1] ? req_data1 : req_data0;
            eng_keys_q <= grant[1] ? req_keys1 : req_keys0;
            rsp_id_q   <= grant[1];
            cnt_q      <= CNT_LOAD;
            eng_en_q   <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= eng_out;
            rsp_valid_q <= 1'b1;
            eng_en_q    <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          // Returning to IDLE here blocks a same-edge accept of the next request.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            last_q      <= rsp_id_q;
            state_q     <= IDLE;
          end
        end
        default: begin
          eng_en_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign eng_data   = eng_data_q;
  assign eng_keys   = eng_keys_q;
  assign eng_enable = eng_en_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Directed bench for aes_enc_arbiter with a known-answer engine stand-in that
// only produces ciphertext after exactly LAT consecutive enabled cycles.
module tb_aes_enc_arbiter;
  import aes_enc_arbiter_pkg::*;

  localparam int LAT = 11;

  localparam block_t PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam block_t CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam keys_t  KS0 = {
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};
  localparam block_t PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam block_t NOT_READY = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  block_t     eng_data, rsp_data, eng_out;
  keys_t      eng_keys;
  keys_t      ks1;
  logic       eng_enable, rsp_valid, rsp_id;
  logic       rsp_ready = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int ecnt     = 0;

  aes_enc_arbiter #(.LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data0  (PT0),
    .req_data1  (PT1),
    .req_keys0  (KS0),
    .req_keys1  (ks1),
    .eng_data   (eng_data),
    .eng_keys   (eng_keys),
    .eng_enable (eng_enable),
    .eng_out    (eng_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine stand-in: real AES answer for the C.1 vector, a keyed mix otherwise.
  function automatic block_t engine_model(input block_t d, input keys_t k);
    block_t acc;
    if (d == PT0 && k == KS0) return CT0;
    acc = d;
    for (int r = 0; r <= NUM_ROUNDS; r++)
      acc = {acc[BLOCK_W-2:0], acc[BLOCK_W-1]} ^ k[KEYS_W-1-r*BLOCK_W -: BLOCK_W];
    return acc;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset)          ecnt <= 0;
    else if (eng_enable) ecnt <= ecnt + 1;
    else                 ecnt <= 0;
  end

  always_comb begin
    eng_out = NOT_READY;
    if (eng_enable && ecnt == LAT - 1) eng_out = engine_model(eng_data, eng_keys);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0] valid;      // req_valid while waiting for accept
    logic [1:0] run_valid;  // req_valid after accept (must not matter)
    int         stall;      // cycles rsp_ready is held low once rsp_valid rises
    logic       exp_id;
    block_t     exp_data;
  } vec_t;

  vec_t vecs[10];
  block_t ct1;

  initial begin
    logic   found;
    int     t_acc;
    int     bad;
    keys_t  exp_keys;
    block_t exp_pt;

    for (int r = 0; r <= NUM_ROUNDS; r++)
      ks1[KEYS_W-1-r*BLOCK_W -: BLOCK_W] = {4{32'h9e3779b9 * 32'(r + 1)}};
    ct1 = engine_model(PT1, ks1);

    vecs[0] = '{2'b01, 2'b01, 0,  1'b0, CT0};
    vecs[1] = '{2'b11, 2'b11, 0,  1'b1, ct1};
    vecs[2] = '{2'b11, 2'b11, 0,  1'b0, CT0};
    vecs[3] = '{2'b11, 2'b11, 0,  1'b1, ct1};
    vecs[4] = '{2'b11, 2'b00, 0,  1'b0, CT0};
    vecs[5] = '{2'b10, 2'b10, 0,  1'b1, ct1};
    vecs[6] = '{2'b11, 2'b11, 0,  1'b0, CT0};
    vecs[7] = '{2'b01, 2'b11, 3,  1'b0, CT0};
    vecs[8] = '{2'b11, 2'b11, 20, 1'b1, ct1};
    vecs[9] = '{2'b01, 2'b10, 0,  1'b0, CT0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready",  128'(req_ready), 128'd0);
    check("rst_eng_enable", 128'(eng_enable), 128'd0);
    check("rst_rsp_valid",  128'(rsp_valid), 128'd0);
    check("rst_rsp_data",   rsp_data, 128'd0);
    check("rst_rsp_id",     128'(rsp_id), 128'd0);
    check("rst_eng_data",   eng_data, 128'd0);
    check("rst_eng_keys0",  128'(eng_keys == '0), 128'd1);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      exp_keys = vecs[i].exp_id ? ks1 : KS0;
      exp_pt   = vecs[i].exp_id ? PT1 : PT0;
      req_valid = vecs[i].valid;
      rsp_ready = (vecs[i].stall == 0);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
        #1;
        if ((req_valid & req_ready) != 2'b00) begin found = 1'b1; break; end
        @(negedge clk);
      end
      check($sformatf("v%0d_accept_seen", i), 128'(found), 128'd1);
      check($sformatf("v%0d_grant", i), 128'(req_ready), vecs[i].exp_id ? 128'd2 : 128'd1);
      t_acc = cyc + 1;

      @(negedge clk);
      req_valid = vecs[i].run_valid;
      #1;
      check($sformatf("v%0d_run_enable", i), 128'(eng_enable), 128'd1);
      check($sformatf("v%0d_run_ready", i),  128'(req_ready), 128'd0);
      check($sformatf("v%0d_eng_data", i),   eng_data, exp_pt);
      check($sformatf("v%0d_eng_keys", i),   128'(eng_keys == exp_keys), 128'd1);

      found = 1'b0;
      for (int k = 0; k < LAT + 10; k++) begin
        if (rsp_valid) begin found = 1'b1; break; end
        @(negedge clk);
        #1;
      end
      check($sformatf("v%0d_rsp_seen", i), 128'(found), 128'd1);
      check($sformatf("v%0d_latency", i),  128'(cyc - t_acc), 128'(LAT));
      check($sformatf("v%0d_rsp_id", i),   128'(rsp_id), 128'(vecs[i].exp_id));
      check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);

      for (int s = 0; s < vecs[i].stall; s++) begin
        check($sformatf("v%0d_hold_valid", i),  128'(rsp_valid), 128'd1);
        check($sformatf("v%0d_hold_data", i),   rsp_data, vecs[i].exp_data);
        check($sformatf("v%0d_hold_id", i),     128'(rsp_id), 128'(vecs[i].exp_id));
        check($sformatf("v%0d_hold_ready", i),  128'(req_ready), 128'd0);
        check($sformatf("v%0d_hold_enable", i), 128'(eng_enable), 128'd0);
        @(negedge clk);
        #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check($sformatf("v%0d_done_valid", i),  128'(rsp_valid), 128'd0);
      check($sformatf("v%0d_no_same_edge", i), 128'(eng_enable), 128'd0);
    end

    // Reset mid-RUN while requester 1 is being served with counter at 5.
    req_valid = 2'b10;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if ((req_valid & req_ready) != 2'b00) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("mid_accept_seen", 128'(found), 128'd1);
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("mid_in_run", 128'(eng_enable), 128'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_enable",   128'(eng_enable), 128'd0);
    check("mid_rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("mid_rst_rsp_data", rsp_data, 128'd0);
    check("mid_rst_rsp_id",   128'(rsp_id), 128'd0);
    check("mid_rst_eng_data", eng_data, 128'd0);
    check("mid_rst_eng_keys0", 128'(eng_keys == '0), 128'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 3 * LAT; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || eng_enable !== 1'b0) bad++;
    end
    check("mid_no_stale_rsp", 128'(bad), 128'd0);

    // Last-served pointer was reset, so requester 0 wins the tie.
    req_valid = 2'b11;
    #1;
    check("post_rst_grant", 128'(req_ready), 128'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
